// File: rtl/conv_1x1_weight_streamer.sv
// conv_1x1_weight_streamer
// Holds a CHANNEL_NUM_IN x CHANNEL_NUM_OUT weight set in a synchronous-read RAM
// and streams it, out-channel-major, into a conv_1x1 weight buffer. After start
// the first weight is pushed unprompted; every later weight answers a
// one-cycle weight_req pulse with a one-cycle valid_weight_out strobe.
module conv_1x1_weight_streamer #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned CHANNEL_NUM_IN  = 256,
  parameter int unsigned CHANNEL_NUM_OUT = 256,
  parameter int unsigned ADDR_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic                  weight_req,
  output logic                  valid_weight_out,
  output logic [DATA_WIDTH-1:0] weight_out,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int unsigned TOTAL = CHANNEL_NUM_IN * CHANNEL_NUM_OUT;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  // One extra bit so the read pointer can step past TOTAL-1 without aliasing.
  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_LAST
  } state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                  pending_q, pending_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0] weight_q;

  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  wr_ok;
  logic                  req_eff;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // The RAM is only writable while idle, and only for in-range indices.
  assign wr_ok = reset && wr_en && (state_q == S_IDLE) && (32'(wr_addr) < TOTAL);

  // A request queued during PRIME is served as if it had arrived in RUN.
  assign req_eff = (state_q == S_RUN) && (weight_req || pending_q);

  // Weight RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Synchronous RAM read; the read register doubles as weight_out so it holds between strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      weight_q <= '0;
    end else if (rd_en) begin
      weight_q <= mem[rd_addr];
    end
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rd_ptr_q  <= '0;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PRIME;
        end
      end
      S_PRIME: begin
        state_d = (TOTAL == 1) ? S_LAST : S_RUN;
      end
      S_RUN: begin
        if (req_eff && (rd_ptr_q == LAST_IDX)) begin
          state_d = S_LAST;
        end
      end
      S_LAST: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read issue, pointer, request bookkeeping and status flags.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    pending_d = pending_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    rd_en     = 1'b0;
    rd_addr   = rd_ptr_q[ADDR_WIDTH-1:0];
    case (state_q)
      S_IDLE: begin
        pending_d = 1'b0;
        if (start) begin
          rd_ptr_d  = '0;
          busy_d    = 1'b1;
          overrun_d = 1'b0;
        end else if (weight_req) begin
          overrun_d = 1'b1;
        end
      end
      S_PRIME: begin
        rd_en    = 1'b1;
        rd_addr  = '0;
        rd_ptr_d = PTR_W'(1);
        if (weight_req) begin
          if (pending_q || (TOTAL == 1)) begin
            overrun_d = 1'b1;
          end else begin
            pending_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (req_eff) begin
          rd_en    = 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
          // A fresh request arriving while a queued one is served stays queued.
          pending_d = weight_req && pending_q;
          if ((rd_ptr_q == LAST_IDX) && weight_req && pending_q) begin
            overrun_d = 1'b1;
            pending_d = 1'b0;
          end
        end
      end
      S_LAST: begin
        pending_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        if (weight_req) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        pending_d = 1'b0;
      end
    endcase
    valid_d = rd_en;
  end

  assign valid_weight_out = valid_q;
  assign weight_out       = weight_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_conv_1x1_weight_streamer.sv
// Bench for conv_1x1_weight_streamer (2 in x 3 out channels, 6 weights).
// Stimulus pushes expected strobes/done pulses into queues; a monitor pops them.
module tb_conv_1x1_weight_streamer;

  localparam int unsigned DW    = 32;
  localparam int unsigned CI    = 2;
  localparam int unsigned CO    = 3;
  localparam int unsigned AW    = 3;
  localparam int unsigned TOTAL = CI * CO;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          weight_req;
  logic          valid_weight_out;
  logic [DW-1:0] weight_out;
  logic          busy;
  logic          done;
  logic          overrun;

  conv_1x1_weight_streamer #(
    .DATA_WIDTH     (DW),
    .CHANNEL_NUM_IN (CI),
    .CHANNEL_NUM_OUT(CO),
    .ADDR_WIDTH     (AW)
  ) dut (
    .clk             (clk),
    .reset           (rst_n),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .start           (start),
    .weight_req      (weight_req),
    .valid_weight_out(valid_weight_out),
    .weight_out      (weight_out),
    .busy            (busy),
    .done            (done),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [DW-1:0] data;
  } strobe_t;

  strobe_t     exp_q[$];
  int unsigned done_q[$];

  // Reference model: weight array plus the bookkeeping of the current pass.
  logic [DW-1:0] ref_mem [TOTAL];
  int unsigned   next_idx    = TOTAL;
  int unsigned   last_strobe = 0;
  int unsigned   start_cyc   = 0;
  int unsigned   done_cyc    = 0;
  bit            ovr_exp     = 1'b0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // A request is served one cycle later, but never before the previous strobe.
  task automatic model_req(input int unsigned n);
    int unsigned s;
    strobe_t     e;
    if (next_idx >= TOTAL) begin
      ovr_exp = 1'b1;
    end else begin
      s = (n + 1 > last_strobe + 1) ? n + 1 : last_strobe + 1;
      e.cyc  = s;
      e.data = ref_mem[next_idx];
      exp_q.push_back(e);
      last_strobe = s;
      next_idx++;
      if (next_idx == TOTAL) begin
        done_cyc = s + 1;
        done_q.push_back(s + 1);
      end
    end
  endtask

  // Drive one cycle of inputs (called at a falling edge) and update the model.
  task automatic step(input bit st, input bit rq, input bit we,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    int unsigned n;
    bit          idle;
    strobe_t     e;
    n          = cyc;
    start      = st;
    weight_req = rq;
    wr_en      = we;
    wr_addr    = wa;
    wr_data    = wd;
    idle       = (n >= done_cyc);
    if (we && idle && (wa < TOTAL)) ref_mem[wa] = wd;
    if (rq) model_req(n);
    if (st && idle) begin
      start_cyc   = n;
      done_cyc    = 32'hFFFF_FFFF;
      next_idx    = 1;
      last_strobe = n + 2;
      ovr_exp     = 1'b0;
      e.cyc       = n + 2;
      e.data      = ref_mem[0];
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    int unsigned n;
    n          = cyc;
    rst_n      = 1'b0;
    start      = 1'b0;
    weight_req = 1'b0;
    wr_en      = 1'b0;
    while (exp_q.size() > 0 && exp_q[$].cyc > n) void'(exp_q.pop_back());
    while (done_q.size() > 0 && done_q[$] > n) void'(done_q.pop_back());
    next_idx  = TOTAL;
    done_cyc  = 0;
    start_cyc = 0;
    ovr_exp   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_valid", valid_weight_out, 0);
    chk("rst_weight", weight_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
  endtask

  // Monitor: sampled just after each rising edge.
  initial begin : monitor
    bit      exp_v;
    bit      exp_d;
    bit      exp_b;
    strobe_t e;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
      while (done_q.size() > 0 && done_q[0] < cyc) void'(done_q.pop_front());
      exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("valid", valid_weight_out, exp_v);
      if (exp_v) begin
        e = exp_q.pop_front();
        if (valid_weight_out) chk("weight_out", weight_out, e.data);
      end
      exp_d = (done_q.size() > 0) && (done_q[0] == cyc);
      chk("done", done, exp_d);
      if (exp_d) void'(done_q.pop_front());
      exp_b = (cyc > start_cyc) && (cyc < done_cyc);
      chk("busy", busy, exp_b);
    end
  end

  initial begin : watchdog
    #200000;
    fails++;
    $display("FAIL timeout: got no finish expected finish by 200000 ns");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin : driver
    int lim;
    int cnt;
    bit rq;
    bit st;
    bit we;
    rst_n      = 1'b0;
    start      = 1'b0;
    weight_req = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("por_valid", valid_weight_out, 0);
    chk("por_weight", weight_out, 0);
    chk("por_busy", busy, 0);
    chk("por_done", done, 0);
    chk("por_overrun", overrun, 0);

    // Load W[k] = 0x3F800000 + k; an out-of-range write is dropped.
    step(1'b0, 1'b0, 1'b1, 3'd7, 32'hBAD0_BAD0);
    for (int k = 0; k < TOTAL; k++) step(1'b0, 1'b0, 1'b1, AW'(k), 32'h3F80_0000 + k);
    while (cyc < 10) idle_cycles(1);

    // Pass 1: start at cycle 10, requests spaced 4 cycles apart.
    step(1'b1, 1'b0, 1'b0, '0, '0);
    idle_cycles(1);
    for (int j = 0; j < TOTAL - 1; j++) begin
      step(1'b0, 1'b1, 1'b0, '0, '0);
      idle_cycles(3);
    end
    idle_cycles(2);
    chk("overrun_pass1", overrun, ovr_exp);

    // Pass 2: back-to-back requests, a dropped write mid-run, then one request too many.
    step(1'b1, 1'b0, 1'b0, '0, '0);
    idle_cycles(1);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b1, 3'd2, 32'hDEAD_BEEF);
    for (int j = 0; j < 3; j++) step(1'b0, 1'b1, 1'b0, '0, '0);
    idle_cycles(3);
    chk("overrun_before_extra", overrun, ovr_exp);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    idle_cycles(2);
    chk("overrun_after_extra", overrun, ovr_exp);

    // Pass 3: request queued during prime, start while busy ignored.
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    chk("overrun_cleared", overrun, ovr_exp);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    idle_cycles(1);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    idle_cycles(4);
    chk("overrun_pass3", overrun, ovr_exp);

    // Pass 4: abort by reset after three weights.
    step(1'b1, 1'b0, 1'b0, '0, '0);
    idle_cycles(1);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    do_reset();
    idle_cycles(3);

    // Randomized passes: random contents, write coincident with start, random request gaps.
    for (int p = 0; p < 5; p++) begin
      for (int w = 0; w < 4; w++)
        step(1'b0, 1'b0, 1'b1, AW'($urandom_range(0, 7)), DW'($urandom));
      step(1'b1, 1'b0, 1'b1, '0, DW'($urandom));
      lim = TOTAL - 1 + int'($urandom_range(0, 1));
      cnt = 0;
      for (int c = 0; c < 80 && cnt < lim; c++) begin
        rq = (c >= 30) ? 1'b1 : 1'(($urandom_range(0, 1)));
        st = !rq && (cyc > start_cyc) && (cyc < done_cyc) && ($urandom_range(0, 7) == 0);
        we = !rq && ($urandom_range(0, 3) == 0);
        step(st, rq, we, AW'($urandom_range(0, 7)), DW'($urandom));
        if (rq) cnt++;
      end
      idle_cycles(4);
      chk("overrun_rand", overrun, ovr_exp);
    end

    idle_cycles(8);
    chk("strobe_queue_drained", exp_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
